// File: rtl/percept_cmd_decoder.sv
// Bit-serial command decoder for a perceptron node: start bit, address, opcode, then a fixed execute window.
// Optional parity bit after the opcode when PERCEPT_CMD_PARITY_EN is defined. Requires ADDR_W >= 2 and OP_W >= 2.
module percept_cmd_decoder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned OP_W     = 3,
  parameter int unsigned EXEC_LEN = 3,
  parameter int unsigned BCAST_EN = 1
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [ADDR_W-1:0] address,
  input  logic              rx,
  output logic [OP_W-1:0]   opcode,
  output logic              op_valid,
  output logic              busy,
  output logic              parity_err
);

`ifdef PERCEPT_CMD_PARITY_EN
  localparam int unsigned SKIP_LOAD = OP_W;
  localparam int unsigned SR_W      = ADDR_W + OP_W;
`else
  localparam int unsigned SKIP_LOAD = OP_W - 1;
  localparam int unsigned SR_W      = ((ADDR_W > OP_W) ? ADDR_W : OP_W) - 1;
`endif
  localparam int unsigned CNT_M1  = ((ADDR_W - 1) > SKIP_LOAD) ? (ADDR_W - 1) : SKIP_LOAD;
  localparam int unsigned CNT_MAX = (CNT_M1 > (EXEC_LEN - 1)) ? CNT_M1 : (EXEC_LEN - 1);
  localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

`ifdef PERCEPT_CMD_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_OP, S_PAR, S_EXEC, S_SKIP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_OP, S_EXEC, S_SKIP} state_t;
`endif

  state_t            r_state;
  logic [SR_W-1:0]   r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [OP_W-1:0]   r_opcode;
  logic              r_op_valid;
  logic              r_busy;
  logic              r_parity_err;

  logic [SR_W-1:0]   w_sr_next;
  logic [ADDR_W-1:0] w_addr_rx;
  logic              w_hit;
  logic              w_cnt_zero;
`ifdef PERCEPT_CMD_PARITY_EN
  logic              w_par_ok;
  logic [OP_W-1:0]   w_op_par;
`else
  logic [OP_W-1:0]   w_op_rx;
`endif

  // Value including the bit being sampled on this edge
  assign w_sr_next  = (r_sr << 1) | SR_W'(rx);
  assign w_addr_rx  = {r_sr[ADDR_W-2:0], rx};
  assign w_hit      = (w_addr_rx == address) || ((BCAST_EN != 0) && (&w_addr_rx));
  assign w_cnt_zero = (r_cnt == '0);
`ifdef PERCEPT_CMD_PARITY_EN
  // Shift register holds address and opcode in full while the parity bit arrives
  assign w_par_ok   = ~(^{r_sr, rx});
  assign w_op_par   = r_sr[OP_W-1:0];
`else
  assign w_op_rx    = {r_sr[OP_W-2:0], rx};
`endif

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state      <= S_IDLE;
      r_sr         <= '0;
      r_cnt        <= '0;
      r_opcode     <= '1;
      r_op_valid   <= 1'b0;
      r_busy       <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_op_valid   <= 1'b0;
      r_parity_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!rx) begin
            r_state <= S_ADDR;
            r_cnt   <= CNT_W'(ADDR_W - 1);
            r_busy  <= 1'b1;
          end
        end
        S_ADDR: begin
          r_sr <= w_sr_next;
          if (w_cnt_zero) begin
            if (w_hit) begin
              r_state <= S_OP;
              r_cnt   <= CNT_W'(OP_W - 1);
            end else begin
              r_state <= S_SKIP;
              r_cnt   <= CNT_W'(SKIP_LOAD);
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_OP: begin
          r_sr <= w_sr_next;
          if (w_cnt_zero) begin
`ifdef PERCEPT_CMD_PARITY_EN
            r_state <= S_PAR;
`else
            if (&w_op_rx) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state    <= S_EXEC;
              r_opcode   <= w_op_rx;
              r_op_valid <= 1'b1;
              r_cnt      <= CNT_W'(EXEC_LEN - 1);
            end
`endif
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
`ifdef PERCEPT_CMD_PARITY_EN
        // NOP frames pass through here unchecked so frame length stays fixed
        S_PAR: begin
          if (&w_op_par) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else if (w_par_ok) begin
            r_state    <= S_EXEC;
            r_opcode   <= w_op_par;
            r_op_valid <= 1'b1;
            r_cnt      <= CNT_W'(EXEC_LEN - 1);
          end else begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_parity_err <= 1'b1;
          end
        end
`endif
        S_EXEC: begin
          if (w_cnt_zero) begin
            r_state  <= S_IDLE;
            r_opcode <= '1;
            r_busy   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        // Foreign frame tail is ignored so its bits never look like a start bit
        S_SKIP: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_opcode <= '1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign opcode     = r_opcode;
  assign op_valid   = r_op_valid;
  assign busy       = r_busy;
  assign parity_err = r_parity_err;

endmodule
